mc_controller: RTL

Multicycle MIPS control unit, the next-generation replacement for the single-cycle controller in the `mips` top. It sequences each instruction over 3–5 cycles against a single unified instruction/data memory with a ready handshake. It drives all datapath enables and mux selects, and it traps illegal opcodes and memory timeouts into a sticky HALT state.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_controller_alu_decoder.sv | 31 +++
 rtl/mc_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU controls, mux selects and error codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU control decode from aluop and funct; flags unsupported funct
// codes when the funct field is being decoded.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory-ready wait states, timeout and sticky HALT.
// Optional bne support is enabled by defining MC_BNE_EN.
module mc_controller
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] op_i6,
  input  logic [5:0] funct_i6,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_en_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o2,
  output logic [1:0] pc_src_o2,
  output logic [2:0] alu_control_o3,
  output logic [1:0] err_o2,
  output logic [3:0] state_o4
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    err, err_nxt;

  logic       bne_en;
  logic       is_bne;
  logic       waiting;
  logic       expired;
  logic       funct_illegal;
  logic [2:0] alu_control;
  logic [1:0] aluop;

  logic       mem_req, mem_write, iord, ir_write, pc_write, branch;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       br_taken;

`ifdef MC_BNE_EN
  assign bne_en = 1'b1;
`else
  assign bne_en = 1'b0;
`endif

  assign is_bne  = bne_en && (op_i6 == OP_BNE);
  assign waiting = is_wait_state(state);
  // A ready arriving in the limit cycle completes the access instead of timing out.
  assign expired = (MEM_TIMEOUT != 0) && waiting && !mem_ready_i && (cnt == CNT_LAST);

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct_i6),
    .alu_control (alu_control),
    .illegal     (funct_illegal)
  );

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    case (state)
      FETCH: begin
        if (mem_ready_i) state_nxt = DECODE;
        else if (expired) begin
          state_nxt = HALT;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        case (op_i6)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default: begin
            if (is_bne) state_nxt = BRANCH;
            else begin
              state_nxt = HALT;
              err_nxt   = ERR_ILLEGAL;
            end
          end
        endcase
      end
      MEMADR: state_nxt = (op_i6 == OP_LW) ? MEMRD : MEMWR;
      MEMRD, MEMWR: begin
        if (mem_ready_i) state_nxt = (state == MEMRD) ? MEMWB : FETCH;
        else if (expired) begin
          state_nxt = HALT;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      EXECUTE: begin
        if (funct_illegal) begin
          state_nxt = HALT;
          err_nxt   = ERR_ILLEGAL;
        end else begin
          state_nxt = ALUWB;
        end
      end
      ADDIEX: state_nxt = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // Counter only runs while a wait state is stalled, so it is zero on every entry.
  assign cnt_nxt = (waiting && !mem_ready_i && !expired) ? cnt + 1'b1 : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= FETCH;
      cnt   <= '0;
      err   <= ERR_NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready_i;
        pc_write  = mem_ready_i;
      end
      DECODE: alu_src_b = SRCB_IMM_SH;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ADDIWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign br_taken = is_bne ? ~zero_i : zero_i;

  // Reset gates every output combinationally so an in-flight access is dropped at once.
  assign mem_req_o      = mem_req & ~reset_i;
  assign mem_write_o    = mem_write & ~reset_i;
  assign iord_o         = iord & ~reset_i;
  assign ir_write_o     = ir_write & ~reset_i;
  assign pc_en_o        = (pc_write | (branch & br_taken)) & ~reset_i;
  assign reg_write_o    = reg_write & ~reset_i;
  assign reg_dst_o      = reg_dst & ~reset_i;
  assign mem_to_reg_o   = mem_to_reg & ~reset_i;
  assign alu_src_a_o    = alu_src_a & ~reset_i;
  assign alu_src_b_o2   = reset_i ? 2'b00 : alu_src_b;
  assign pc_src_o2      = reset_i ? 2'b00 : pc_src;
  assign alu_control_o3 = reset_i ? 3'b000 : alu_control;
  assign err_o2         = reset_i ? 2'b00 : err;
  assign state_o4       = reset_i ? 4'd0 : state;

endmodule
